inst_fetch_responder: RTL

Multi-cycle instruction-memory responder. It is the memory-side end of the fetch interface.
- Accepts word-fetch requests from the IF stage and returns the instruction after a fixed, parameterised latency.
- Drives a stall that feeds the fetch stage's hazard/PC-hold input.
- Honours branch flushes by cancelling in-flight requests.
- Sits between the IF stage and a word-addressed program store, which is loaded through a side port.

---
 rtl/inst_fetch_responder_pkg.sv | 23 ++
 rtl/inst_fetch_responder_if.sv | 26 ++
 rtl/inst_fetch_responder_mem.sv | 30 +++
 rtl/inst_fetch_responder.sv | 116 +++++++++++
 4 files changed

// File: rtl/inst_fetch_responder_pkg.sv
// Shared types and constants for the instruction-fetch responder.
//   fetch_state_t : responder FSM states
//   WORD_W        : instruction/bus word width
//   NOP           : word returned for addresses outside the program store
//   word_in_range : true when a byte address maps to a word below depth
package arm_if_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP = 32'hE1A00000;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } fetch_state_t;

  // Uses the whole address so that high bits never alias into the store.
  function automatic logic word_in_range(input logic [WORD_W-1:0] byte_addr,
                                         input int unsigned depth);
    return (byte_addr >> 2) < depth;
  endfunction

endpackage

// File: rtl/inst_fetch_responder_if.sv
// Fetch bus between the IF stage (master) and the memory-side responder (slave).
//   req_valid/req_addr/flush            : IF stage -> responder
//   req_ready/resp_*/stall              : responder -> IF stage
interface inst_fetch_responder_if;

  logic                             req_valid;
  logic [arm_if_pkg::WORD_W-1:0]    req_addr;
  logic                             req_ready;
  logic                             flush;
  logic                             resp_valid;
  logic [arm_if_pkg::WORD_W-1:0]    resp_inst;
  logic [arm_if_pkg::WORD_W-1:0]    resp_addr;
  logic                             resp_err;
  logic                             stall;

  modport master (
    output req_valid, req_addr, flush,
    input  req_ready, resp_valid, resp_inst, resp_addr, resp_err, stall
  );

  modport slave (
    input  req_valid, req_addr, flush,
    output req_ready, resp_valid, resp_inst, resp_addr, resp_err, stall
  );

endinterface

// File: rtl/inst_fetch_responder_mem.sv
// Program store: MEM_DEPTH x 32 words, synchronous write, combinational read.
//   clk     : write clock
//   we_i    : write enable (caller has already range-checked the address)
//   waddr_i : write word index
//   wdata_i : write data
//   raddr_i : read word index
//   rdata_o : read data (reflects contents before a same-edge write)
module inst_mem_array #(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_fetch_responder.sv
// Memory-side end of the instruction-fetch interface. Accepts one word fetch
// at a time and answers LATENCY cycles after accept; a flush cancels it.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fetch handshake (slave side)
//   ld_en    : program-load write enable
//   ld_addr  : program-load byte address
//   ld_data  : program-load data
module inst_fetch_responder
  import arm_if_pkg::*;
#(
  parameter int unsigned       MEM_DEPTH = 1024,
  parameter int unsigned       LATENCY   = 3,
  parameter logic [WORD_W-1:0] NOP_WORD  = NOP
) (
  input  logic                   clk,
  input  logic                   rst,
  inst_fetch_responder_if.slave  bus,
  input  logic                   ld_en,
  input  logic [WORD_W-1:0]      ld_addr,
  input  logic [WORD_W-1:0]      ld_data
);

  localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);
  localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  fetch_state_t      state_q;
  logic [3:0]        cnt_q;
  logic [WORD_W-1:0] addr_q;
  logic              err_q;
  logic [WORD_W-1:0] inst_q;
  logic [WORD_W-1:0] raddr_q;
  logic              rerr_q;

  logic [WORD_W-1:0] rd_addr;
  logic [WORD_W-1:0] mem_rdata;
  logic [WORD_W-1:0] rd_word;
  logic              rd_err;
  logic              mem_we;
  logic              resp_valid;

  // In IDLE the only way into RESP is a LATENCY==1 accept, where addr_q is
  // not yet captured, so the read is taken straight from the request.
  assign rd_addr = (state_q == IDLE) ? bus.req_addr : addr_q;
  assign rd_word = word_in_range(rd_addr, MEM_DEPTH) ? mem_rdata : NOP_WORD;
  assign rd_err  = (rd_addr[1:0] != 2'b00);
  assign mem_we  = ld_en & word_in_range(ld_addr, MEM_DEPTH);

  inst_mem_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (IDX_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (ld_addr[IDX_W+1:2]),
    .wdata_i (ld_data),
    .raddr_i (rd_addr[IDX_W+1:2]),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      inst_q  <= '0;
      raddr_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid && !bus.flush) begin
            addr_q <= bus.req_addr;
            err_q  <= (bus.req_addr[1:0] != 2'b00);
            if (LATENCY == 1) begin
              state_q <= RESP;
              inst_q  <= rd_word;
              raddr_q <= rd_addr;
              rerr_q  <= rd_err;
            end else begin
              cnt_q   <= CNT_INIT;
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (bus.flush) begin
            state_q <= IDLE;
          end else if (cnt_q == '0) begin
            state_q <= RESP;
            inst_q  <= rd_word;
            raddr_q <= rd_addr;
            rerr_q  <= rd_err;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign resp_valid     = (state_q == RESP) & ~bus.flush;
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid;
  assign bus.resp_inst  = inst_q;
  assign bus.resp_addr  = raddr_q;
  assign bus.resp_err   = rerr_q;
  assign bus.stall      = bus.req_valid & ~resp_valid;

endmodule
